// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - register file with write bypass and per-register pending-write scoreboard
module reg_file_scoreboard #(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 15,
  parameter int ADDR_W      = 4,
  parameter int RESET_INDEX = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_src_1_reg,
  input  logic [ADDR_W-1:0] read_src_2_reg,
  output logic [DATA_W-1:0] read_src_1_data,
  output logic [DATA_W-1:0] read_src_2_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] write_src_reg,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dest_reg,
  output logic              busy_1,
  output logic              busy_2,
  output logic [ADDR_W:0]   busy_count
);

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]     busy_count_q, busy_count_d;

  logic rd1_valid, rd2_valid, wb_valid, issue_valid;
  logic wb_hit_1, wb_hit_2;

  assign rd1_valid   = {1'b0, read_src_1_reg} < NUM_REGS_W;
  assign rd2_valid   = {1'b0, read_src_2_reg} < NUM_REGS_W;
  assign wb_valid    = wb_en && ({1'b0, write_src_reg} < NUM_REGS_W);
  assign issue_valid = issue_en && ({1'b0, issue_dest_reg} < NUM_REGS_W);

  assign wb_hit_1 = wb_valid && (write_src_reg == read_src_1_reg);
  assign wb_hit_2 = wb_valid && (write_src_reg == read_src_2_reg);

  always_comb begin
    regs_d = regs_q;
    if (wb_valid) begin
      regs_d[write_src_reg] = wb_value;
    end
  end

  // A same-cycle issue beats a retire: the newly issued writer is still in flight.
  always_comb begin
    busy_d       = busy_q;
    busy_count_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (issue_valid && (issue_dest_reg == ADDR_W'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wb_valid && (write_src_reg == ADDR_W'(r))) begin
        busy_d[r] = 1'b0;
      end
      busy_count_d = busy_count_d + (ADDR_W+1)'(busy_d[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (RESET_INDEX != 0) ? DATA_W'(i) : '0;
      end
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  always_comb begin
    read_src_1_data = '0;
    if (rd1_valid) begin
      read_src_1_data = wb_hit_1 ? wb_value : regs_q[read_src_1_reg];
    end
  end

  always_comb begin
    read_src_2_data = '0;
    if (rd2_valid) begin
      read_src_2_data = wb_hit_2 ? wb_value : regs_q[read_src_2_reg];
    end
  end

  // A write-back landing this cycle resolves the hazard through the bypass path.
  assign busy_1     = rd1_valid && busy_q[read_src_1_reg] && !wb_hit_1;
  assign busy_2     = rd2_valid && busy_q[read_src_2_reg] && !wb_hit_2;
  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb/tb_reg_file_scoreboard.sv - self-checking bench for reg_file_scoreboard
module tb_reg_file_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  read_src_1_reg, read_src_2_reg;
  logic [31:0] read_src_1_data, read_src_2_data;
  logic        wb_en;
  logic [3:0]  write_src_reg;
  logic [31:0] wb_value;
  logic        issue_en;
  logic [3:0]  issue_dest_reg;
  logic        busy_1, busy_2;
  logic [4:0]  busy_count;

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] m_regs [15];
  bit          m_busy [15];

  always #5 clk = ~clk;

  reg_file_scoreboard dut (
    .clk             (clk),
    .rst             (rst),
    .read_src_1_reg  (read_src_1_reg),
    .read_src_2_reg  (read_src_2_reg),
    .read_src_1_data (read_src_1_data),
    .read_src_2_data (read_src_2_data),
    .wb_en           (wb_en),
    .write_src_reg   (write_src_reg),
    .wb_value        (wb_value),
    .issue_en        (issue_en),
    .issue_dest_reg  (issue_dest_reg),
    .busy_1          (busy_1),
    .busy_2          (busy_2),
    .busy_count      (busy_count)
  );

  task automatic model_reset();
    for (int i = 0; i < 15; i++) begin
      m_regs[i] = 32'(i);
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 15; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    if (a >= 15) return 32'd0;
    if (wb_en && write_src_reg == a) return wb_value;
    return m_regs[a];
  endfunction

  function automatic logic model_busy(input logic [3:0] a);
    if (a >= 15) return 1'b0;
    return m_busy[a] && !(wb_en && write_src_reg == a);
  endfunction

  task automatic idle();
    wb_en = 0; issue_en = 0; write_src_reg = 0; wb_value = 0; issue_dest_reg = 0;
  endtask

  // Advance one clock edge, apply the architectural rules to the model, settle 1 ns after.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (wb_en && write_src_reg < 15) begin
        m_regs[write_src_reg] = wb_value;
        m_busy[write_src_reg] = 1'b0;
      end
      if (issue_en && issue_dest_reg < 15) m_busy[issue_dest_reg] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    read_src_1_reg = 0; read_src_2_reg = 0;
    rst = 1;
    model_reset();
    tick(); tick();
    rst = 0;
    read_src_1_reg = 3; read_src_2_reg = 14;
    #1;
    n_run++; if (read_src_1_data !== 32'd3) begin n_fail++; $display("FAIL reset_rd1 got %0h exp 3", read_src_1_data); end
    n_run++; if (read_src_2_data !== 32'd14) begin n_fail++; $display("FAIL reset_rd2 got %0h exp e", read_src_2_data); end
    n_run++; if ({busy_1, busy_2} !== 2'b00) begin n_fail++; $display("FAIL reset_busy got %b exp 00", {busy_1, busy_2}); end
    n_run++; if (busy_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", busy_count); end
  endtask

  task automatic test_write_read();
    idle();
    wb_en = 1; write_src_reg = 5; wb_value = 32'hDEADBEEF;
    read_src_1_reg = 5; read_src_2_reg = 4;
    #1;
    n_run++; if (read_src_1_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_bypass got %h exp deadbeef", read_src_1_data); end
    n_run++; if (read_src_2_data !== 32'd4) begin n_fail++; $display("FAIL wr_other got %h exp 4", read_src_2_data); end
    tick();
    idle();
    #1;
    n_run++; if (read_src_1_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_stored got %h exp deadbeef", read_src_1_data); end
  endtask

  task automatic test_raw();
    idle();
    issue_en = 1; issue_dest_reg = 7;
    tick();
    idle();
    read_src_1_reg = 7;
    #1;
    n_run++; if (busy_1 !== 1'b1) begin n_fail++; $display("FAIL raw_busy got %b exp 1", busy_1); end
    n_run++; if (busy_count !== 5'd1) begin n_fail++; $display("FAIL raw_count got %0d exp 1", busy_count); end
    tick();
    wb_en = 1; write_src_reg = 7; wb_value = 32'h55;
    #1;
    n_run++; if (busy_1 !== 1'b0) begin n_fail++; $display("FAIL raw_wb_busy got %b exp 0", busy_1); end
    n_run++; if (read_src_1_data !== 32'h55) begin n_fail++; $display("FAIL raw_wb_bypass got %h exp 55", read_src_1_data); end
    tick();
    idle();
    #1;
    n_run++; if (busy_1 !== 1'b0) begin n_fail++; $display("FAIL raw_after_busy got %b exp 0", busy_1); end
    n_run++; if (busy_count !== 5'd0) begin n_fail++; $display("FAIL raw_after_count got %0d exp 0", busy_count); end
  endtask

  task automatic test_issue_wb_same();
    idle();
    issue_en = 1; issue_dest_reg = 2;
    tick();
    issue_en = 1; issue_dest_reg = 2;
    wb_en = 1; write_src_reg = 2; wb_value = 32'h1234;
    tick();
    idle();
    read_src_1_reg = 2;
    #1;
    n_run++; if (busy_1 !== 1'b1) begin n_fail++; $display("FAIL same_busy got %b exp 1", busy_1); end
    n_run++; if (busy_count !== 5'd1) begin n_fail++; $display("FAIL same_count got %0d exp 1", busy_count); end
    n_run++; if (read_src_1_data !== 32'h1234) begin n_fail++; $display("FAIL same_data got %h exp 1234", read_src_1_data); end
    wb_en = 1; write_src_reg = 2; wb_value = 32'h2;
    tick();
    idle();
  endtask

  task automatic test_fill();
    idle();
    for (int i = 0; i < 15; i++) begin
      issue_en = 1; issue_dest_reg = 4'(i);
      tick();
    end
    idle();
    #1;
    n_run++; if (busy_count !== 5'd15) begin n_fail++; $display("FAIL fill_count got %0d exp 15", busy_count); end
    issue_en = 1; issue_dest_reg = 15;
    wb_en = 1; write_src_reg = 15; wb_value = 32'hFFFF_FFFF;
    read_src_1_reg = 15; read_src_2_reg = 14;
    #1;
    n_run++; if (read_src_1_data !== 32'd0) begin n_fail++; $display("FAIL oor_read got %h exp 0", read_src_1_data); end
    n_run++; if (busy_1 !== 1'b0) begin n_fail++; $display("FAIL oor_busy got %b exp 0", busy_1); end
    n_run++; if (read_src_2_data !== m_regs[14]) begin n_fail++; $display("FAIL oor_rd14 got %h exp %h", read_src_2_data, m_regs[14]); end
    tick();
    idle();
    #1;
    n_run++; if (busy_count !== 5'd15) begin n_fail++; $display("FAIL oor_count got %0d exp 15", busy_count); end
    for (int i = 0; i < 15; i++) begin
      wb_en = 1; write_src_reg = 4'(i); wb_value = $urandom;
      tick();
    end
    idle();
    #1;
    n_run++; if (busy_count !== 5'd0) begin n_fail++; $display("FAIL retire_count got %0d exp 0", busy_count); end
  endtask

  task automatic test_async_reset();
    idle();
    for (int i = 1; i <= 3; i++) begin
      issue_en = 1; issue_dest_reg = 4'(i);
      tick();
    end
    idle();
    wb_en = 1; write_src_reg = 4; wb_value = 32'hABCD;
    tick();
    idle();
    read_src_1_reg = 4; read_src_2_reg = 2;
    #1;
    n_run++; if (busy_count !== 5'd3) begin n_fail++; $display("FAIL ar_pre_count got %0d exp 3", busy_count); end
    n_run++; if (read_src_1_data !== 32'hABCD) begin n_fail++; $display("FAIL ar_pre_data got %h exp abcd", read_src_1_data); end
    #2;
    rst = 1;
    #1;
    n_run++; if (busy_count !== 5'd0) begin n_fail++; $display("FAIL ar_count got %0d exp 0", busy_count); end
    n_run++; if (read_src_1_data !== 32'd4) begin n_fail++; $display("FAIL ar_data got %h exp 4", read_src_1_data); end
    n_run++; if (busy_2 !== 1'b0) begin n_fail++; $display("FAIL ar_busy got %b exp 0", busy_2); end
    model_reset();
    #1;
    rst = 0;
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      read_src_1_reg = 4'($urandom_range(0, 15));
      read_src_2_reg = 4'($urandom_range(0, 15));
      wb_en          = 1'($urandom_range(0, 1));
      write_src_reg  = ($urandom_range(0, 3) == 0) ? read_src_1_reg : 4'($urandom_range(0, 15));
      wb_value       = $urandom;
      issue_en       = 1'($urandom_range(0, 1));
      issue_dest_reg = 4'($urandom_range(0, 15));
      #1;
      n_run++; if (read_src_1_data !== model_read(read_src_1_reg)) begin n_fail++; $display("FAIL rnd_rd1 it %0d got %h exp %h", k, read_src_1_data, model_read(read_src_1_reg)); end
      n_run++; if (read_src_2_data !== model_read(read_src_2_reg)) begin n_fail++; $display("FAIL rnd_rd2 it %0d got %h exp %h", k, read_src_2_data, model_read(read_src_2_reg)); end
      n_run++; if (busy_1 !== model_busy(read_src_1_reg)) begin n_fail++; $display("FAIL rnd_busy1 it %0d got %b exp %b", k, busy_1, model_busy(read_src_1_reg)); end
      n_run++; if (busy_2 !== model_busy(read_src_2_reg)) begin n_fail++; $display("FAIL rnd_busy2 it %0d got %b exp %b", k, busy_2, model_busy(read_src_2_reg)); end
      n_run++; if (int'(busy_count) != model_count()) begin n_fail++; $display("FAIL rnd_count it %0d got %0d exp %0d", k, busy_count, model_count()); end
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    read_src_1_reg = 0; read_src_2_reg = 0;
    model_reset();
    test_reset();
    test_write_read();
    test_raw();
    test_issue_wb_same();
    test_fill();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
